// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2,
    ARB_ERR  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_align.sv
// Access alignment check: flags size/address pairs memory cannot serve.
module mem_port_arbiter_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic       misaligned_o
);

  // Byte never faults, half needs an even address, word needs 4-byte alignment.
  always_comb begin
    misaligned_o = 1'b1;
    case (size_i)
      MEM_SIZE_BYTE: misaligned_o = 1'b0;
      MEM_SIZE_HALF: misaligned_o = addr_lo_i[0];
      MEM_SIZE_WORD: misaligned_o = |addr_lo_i;
      default:       misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and LSU.
// LSU wins contention until it has taken MAX_LSU_STREAK contested grants,
// then fetch is forced through once.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  input  logic                  if_flush,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic                  lsu_req_we,
  input  logic [1:0]            lsu_req_size,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  output logic                  lsu_rsp_valid,
  output logic                  lsu_rsp_err,
  output logic [DATA_WIDTH-1:0] lsu_rsp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_we,
  output logic [1:0]            mem_req_size,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata
);

  localparam int SW = $clog2(MAX_LSU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, owner_d;
  logic                  drop_q, drop_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  if_rv_q, if_rv_d;
  logic [DATA_WIDTH-1:0] if_rd_q, if_rd_d;
  logic                  lsu_rv_q, lsu_rv_d;
  logic                  lsu_err_q, lsu_err_d;
  logic [DATA_WIDTH-1:0] lsu_rd_q, lsu_rd_d;

  logic grant_if, grant_lsu, lsu_misaligned, flush_hit, drop_now;

  mem_port_arbiter_align u_align (
    .size_i       (lsu_req_size),
    .addr_lo_i    (lsu_req_addr[1:0]),
    .misaligned_o (lsu_misaligned)
  );

  // IDLE arbitration; a flushing fetch is never granted.
  assign grant_if  = (state_q == ARB_IDLE) && if_req_valid && !if_flush &&
                     (!lsu_req_valid || (streak_q == STREAK_MAX));
  assign grant_lsu = (state_q == ARB_IDLE) && lsu_req_valid && !grant_if;

  assign if_req_ready  = grant_if;
  assign lsu_req_ready = grant_lsu;

  // A fetch flushed while in flight still completes on the bus, silently.
  assign flush_hit = (owner_q == OWN_IF) && if_flush;
  assign drop_now  = drop_q || flush_hit;

  assign mem_req_valid = (state_q == ARB_REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_size  = size_q;
  assign mem_req_wdata = wdata_q;
  assign if_rsp_valid  = if_rv_q;
  assign if_rsp_data   = if_rd_q;
  assign lsu_rsp_valid = lsu_rv_q;
  assign lsu_rsp_err   = lsu_err_q;
  assign lsu_rsp_data  = lsu_rd_q;

  // Next-state, capture and response-pulse logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    drop_d    = drop_q;
    streak_d  = streak_q;
    addr_d    = addr_q;
    we_d      = we_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    if_rv_d   = 1'b0;
    if_rd_d   = if_rd_q;
    lsu_rv_d  = 1'b0;
    lsu_err_d = 1'b0;
    lsu_rd_d  = lsu_rd_q;
    case (state_q)
      ARB_IDLE: begin
        drop_d = 1'b0;
        if (grant_if) begin
          state_d  = ARB_REQ;
          owner_d  = OWN_IF;
          addr_d   = if_req_addr;
          we_d     = 1'b0;
          size_d   = MEM_SIZE_WORD;
          wdata_d  = '0;
          streak_d = '0;
        end else if (grant_lsu) begin
          state_d = lsu_misaligned ? ARB_ERR : ARB_REQ;
          owner_d = OWN_LSU;
          addr_d  = lsu_req_addr;
          we_d    = lsu_req_we;
          size_d  = lsu_req_size;
          wdata_d = lsu_req_wdata;
          if (!if_req_valid)                streak_d = '0;
          else if (streak_q != STREAK_MAX)  streak_d = streak_q + SW'(1);
        end else if (!if_req_valid) begin
          streak_d = '0;
        end
      end
      ARB_REQ: begin
        drop_d = drop_now;
        if (mem_req_ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        drop_d = drop_now;
        if (mem_rsp_valid) begin
          state_d = ARB_IDLE;
          if (owner_q == OWN_IF) begin
            if_rv_d = !drop_now;
            if_rd_d = mem_rsp_rdata;
          end else begin
            lsu_rv_d = 1'b1;
            lsu_rd_d = mem_rsp_rdata;
          end
        end
      end
      ARB_ERR: begin
        state_d   = ARB_IDLE;
        lsu_rv_d  = 1'b1;
        lsu_err_d = 1'b1;
        lsu_rd_d  = '0;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_IF;
      drop_q    <= 1'b0;
      streak_q  <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      wdata_q   <= '0;
      if_rv_q   <= 1'b0;
      if_rd_q   <= '0;
      lsu_rv_q  <= 1'b0;
      lsu_err_q <= 1'b0;
      lsu_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      drop_q    <= drop_d;
      streak_q  <= streak_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      if_rv_q   <= if_rv_d;
      if_rd_q   <= if_rd_d;
      lsu_rv_q  <= lsu_rv_d;
      lsu_err_q <= lsu_err_d;
      lsu_rd_q  <= lsu_rd_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Transaction-level bench for mem_port_arbiter: directed cases then random traffic.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req_valid, if_req_ready, if_flush, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_rsp_valid, lsu_rsp_err;
  logic [1:0]  lsu_req_size;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [1:0]  mem_req_size;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_LSU_STREAK(MAXS)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_we(lsu_req_we), .lsu_req_size(lsu_req_size), .lsu_req_wdata(lsu_req_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_size(mem_req_size), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state: contested-LSU run length and the pending response pulse.
  int          streak_m;
  bit          pend_if, pend_lsu, pend_err;
  logic [31:0] pend_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Response outputs for this cycle against whatever the model expects.
  task automatic check_out();
    chk("if_rsp_valid", if_rsp_valid, pend_if);
    if (pend_if) chk("if_rsp_data", if_rsp_data, pend_data);
    chk("lsu_rsp_valid", lsu_rsp_valid, pend_lsu);
    chk("lsu_rsp_err", lsu_rsp_err, pend_err);
    if (pend_lsu) chk("lsu_rsp_data", lsu_rsp_data, pend_data);
    pend_if = 0; pend_lsu = 0; pend_err = 0;
  endtask

  // One arbitration cycle starting in IDLE, plus the granted transaction if any.
  task automatic txn(input bit if_v, input bit lsu_v, input bit fl,
                     input logic [31:0] ia, input logic [31:0] la, input bit lwe,
                     input logic [1:0] lsz, input logic [31:0] lwd,
                     input int k, input int lat, input logic [31:0] rd,
                     input bit fmid, input bit stray);
    int g;
    bit mis;
    logic [31:0] ea, ew;
    logic [1:0]  es;
    bit          ewe;
    @(negedge clk);
    if_req_valid = if_v; if_req_addr = ia; if_flush = fl;
    lsu_req_valid = lsu_v; lsu_req_addr = la; lsu_req_we = lwe;
    lsu_req_size = lsz; lsu_req_wdata = lwd;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = $urandom;
    #1;
    check_out();
    // 0 = nobody, 1 = fetch, 2 = LSU
    if (if_v && !fl && (!lsu_v || streak_m == MAXS)) g = 1;
    else if (lsu_v) g = 2;
    else g = 0;
    chk("if_req_ready", if_req_ready, g == 1);
    chk("lsu_req_ready", lsu_req_ready, g == 2);
    chk("idle_mem_req_valid", mem_req_valid, 0);
    if (g == 1 || !if_v) streak_m = 0;
    else if (g == 2 && streak_m < MAXS) streak_m = streak_m + 1;
    if (g == 0) return;
    if (g == 1) begin ea = ia; ewe = 0; es = MEM_SIZE_WORD; ew = 0; end
    else begin ea = la; ewe = lwe; es = lsz; ew = lwd; end
    mis = (g == 2) && ((lsz == MEM_SIZE_HALF && la[0]) ||
                       (lsz == MEM_SIZE_WORD && la[1:0] != 2'b00) || lsz == 2'b11);
    if (mis) begin
      @(negedge clk);
      if_flush = 0;
      #1;
      check_out();
      chk("err_no_mem_req", mem_req_valid, 0);
      pend_lsu = 1; pend_err = 1; pend_data = 0;
      return;
    end
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      if_flush = 0;
      mem_req_ready = (i == k);
      mem_rsp_valid = stray && (i == 1);
      mem_rsp_rdata = $urandom;
      #1;
      check_out();
      chk("req_valid", mem_req_valid, 1);
      chk("req_addr", mem_req_addr, ea);
      chk("req_we", mem_req_we, ewe);
      chk("req_size", mem_req_size, es);
      if (ewe) chk("req_wdata", mem_req_wdata, ew);
      chk("busy_lsu_ready", lsu_req_ready, 0);
    end
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      mem_req_ready = 0;
      if_flush = fmid && (j == 1);
      mem_rsp_valid = (j == lat);
      mem_rsp_rdata = (j == lat) ? rd : $urandom;
      #1;
      check_out();
      chk("wait_req_valid", mem_req_valid, 0);
    end
    if (g == 1) pend_if = !fmid;
    else pend_lsu = 1;
    pend_data = rd;
  endtask

  initial begin
    streak_m = 0; pend_if = 0; pend_lsu = 0; pend_err = 0; pend_data = 0;
    reset_n = 0;
    if_req_valid = 0; if_req_addr = 0; if_flush = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_we = 0; lsu_req_size = 0; lsu_req_wdata = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    check_out();
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_if_ready", if_req_ready, 0);
    chk("rst_lsu_ready", lsu_req_ready, 0);
    reset_n = 1;

    // Fetch alone, immediate ready, one-cycle latency.
    txn(1, 0, 0, 32'h0100_0000, 0, 0, 0, 0, 1, 1, 32'h0000_0013, 0, 0);
    // Both requesters held: four LSU grants, then fetch, then LSU again.
    for (int n = 0; n < 6; n++)
      txn(1, 1, 0, 32'h0100_0040 + n * 4, 32'h0100_0100 + n * 4, 0,
          MEM_SIZE_WORD, 0, 1, 1, 32'hA000_0000 + n, 0, 0);
    // Store with a stalled memory port.
    txn(0, 1, 0, 0, 32'h0100_0004, 1, MEM_SIZE_WORD, 32'hDEAD_BEEF, 4, 1, 32'h0, 0, 0);
    // Misaligned halfword load never reaches memory.
    txn(0, 1, 0, 0, 32'h0100_0001, 0, MEM_SIZE_HALF, 0, 1, 1, 0, 0, 0);
    // Fetch flushed while waiting, then a normal fetch.
    txn(1, 0, 0, 32'h0100_0008, 0, 0, 0, 0, 1, 2, 32'h1234_5678, 1, 0);
    txn(1, 0, 0, 32'h0100_000C, 0, 0, 0, 0, 2, 1, 32'h0000_0093, 0, 0);
    // Fetch requested in the same cycle as a flush is refused.
    txn(1, 0, 1, 32'h0100_0010, 0, 0, 0, 0, 1, 1, 0, 0, 0);

    // Reset while a fetch waits for memory; the late response must vanish.
    @(negedge clk);
    check_out();
    if_req_valid = 1; if_req_addr = 32'h0100_0020; if_flush = 0;
    lsu_req_valid = 0; mem_req_ready = 1; mem_rsp_valid = 0;
    #1;
    chk("rst_case_accept", if_req_ready, 1);
    @(negedge clk);
    if_req_valid = 0;
    @(negedge clk);
    mem_req_ready = 0;
    reset_n = 0;
    #1;
    chk("midrst_mem_req_valid", mem_req_valid, 0);
    chk("midrst_if_rsp_valid", if_rsp_valid, 0);
    @(negedge clk);
    reset_n = 1;
    mem_rsp_valid = 1; mem_rsp_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_rsp_valid = 0;
    #1;
    chk("late_if_rsp_valid", if_rsp_valid, 0);
    chk("late_lsu_rsp_valid", lsu_rsp_valid, 0);
    chk("late_mem_req_valid", mem_req_valid, 0);
    streak_m = 0;
    txn(1, 0, 0, 32'h0100_0024, 0, 0, 0, 0, 1, 1, 32'h0000_0033, 0, 0);

    // Random mixed traffic.
    for (int n = 0; n < 80; n++)
      txn($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          32'h0100_0000 | ($urandom & 32'h0000_0FFC), 32'h0100_0000 | ($urandom & 32'h0000_0FFF),
          $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom,
          $urandom_range(1, 3), $urandom_range(1, 3), $urandom,
          $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);

    @(negedge clk);
    if_req_valid = 0; lsu_req_valid = 0; if_flush = 0; mem_rsp_valid = 0;
    #1;
    check_out();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single unified memory port between instruction fetch (IF) and the load/store unit (LSU), one outstanding transaction at a time. It sits between the pipeline's fetch/memory stages and the memory model based at MEM_BASE_ADDR. It arbitrates with LSU priority, bounds IF starvation, discards flushed fetches and rejects misaligned LSU accesses without touching memory.

## Interface
- MAX_LSU_STREAK, 4: consecutive contested LSU grants before IF is forced through (≥1)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req_valid / if_req_ready  in/out  1  fetch request handshake
- if_req_addr  in  ADDR_WIDTH  fetch address (always word read)
- if_flush  in  1  drop any in-flight or same-cycle fetch
- if_rsp_valid  out  1  fetch data valid (1-cycle pulse)
- if_rsp_data  out  DATA_WIDTH  fetched word
- lsu_req_valid / lsu_req_ready  in/out  1  LSU request handshake
- lsu_req_addr  in  ADDR_WIDTH; lsu_req_we  in  1; lsu_req_size  in  2 (MEM_SIZE_*); lsu_req_wdata  in  DATA_WIDTH
- lsu_rsp_valid  out  1; lsu_rsp_err  out  1; lsu_rsp_data  out  DATA_WIDTH  raw word, no extension
- mem_req_valid  out  1 / mem_req_ready  in  1  downstream request handshake
- mem_req_addr  out  ADDR_WIDTH; mem_req_we  out  1; mem_req_size  out  2; mem_req_wdata  out  DATA_WIDTH
- mem_rsp_valid  in  1; mem_rsp_rdata  in  DATA_WIDTH  response/ack (stores ack too)

## Operation
- FSM: IDLE, REQ, WAIT, ERR. Owner register {IF, LSU}; drop flag; streak counter.
- IDLE: x_req_ready combinational, high only for the granted requester. Grant: LSU if lsu_req_valid, except IF when both valid and streak == MAX_LSU_STREAK. IF never granted in a cycle with if_flush=1.
- Accept: capture addr/we/size/wdata (IF: we=0, size=MEM_SIZE_WORD). LSU misaligned (HALF with addr[0], WORD with addr[1:0]≠0, size 2'b11) → ERR; else → REQ.
- REQ: mem_req_valid=1 with captured fields held stable; on mem_req_ready → WAIT.
- WAIT: on mem_rsp_valid → IDLE; register response to owner next cycle unless drop set.
- ERR: → IDLE; next cycle lsu_rsp_valid=1, lsu_rsp_err=1, lsu_rsp_data=0.
- if_flush while owner=IF in REQ/WAIT sets drop; the memory transaction completes but if_rsp_valid is suppressed. Drop clears on return to IDLE. LSU unaffected by flush.
- Streak: +1 on LSU grant while if_req_valid=1; cleared on IF grant or any IDLE cycle with if_req_valid=0; saturates.
- mem_rsp_valid outside WAIT ignored.

## Timing
- Reset: state IDLE, all outputs 0 (ready signals follow IDLE arbitration combinationally), streak 0, drop 0.
- Accept at T; mem_req_valid from T+1; mem_req_ready at T+k; mem_rsp_valid at T+k+L (L≥1); rsp_valid pulse at T+k+L+1, which is also an IDLE cycle, so the next accept can coincide with it.
- Minimum back-to-back: 3 cycles per transaction (k=1, L=1). Error path: response at T+2.
- Reset mid-transaction: immediate return to IDLE, no response delivered, late mem_rsp_valid ignored.

## Structure
- Add to constants_pkg: arb_state_t enum (ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_ERR), arb_owner_t (OWN_IF, OWN_LSU), MEM_SIZE_* reused.
- Single module; optional sub-module mem_align_check (size+addr → misaligned) shared with the LSU.

## Test plan
- IF only, addr 0x0100_0000, mem ready immediately, L=1, rdata 0x0000_0013 → if_rsp_valid at T+3 with 0x0000_0013; mem_req_size=WORD, we=0.
- IF and LSU both valid continuously, MAX_LSU_STREAK=4 → grant order LSU,LSU,LSU,LSU,IF,LSU…
- LSU store addr 0x0100_0004, WORD, wdata 0xDEAD_BEEF, mem_req_ready delayed 3 cycles → fields stable for all REQ cycles, lsu_rsp_valid after ack, err=0.
- LSU HALF load at 0x0100_0001 → no mem_req_valid, lsu_rsp_valid at T+2, err=1, data=0.
- IF accepted, if_flush in WAIT, mem returns 0x1234_5678 → no if_rsp_valid; next IF granted normally.
- reset_n low during WAIT, mem_rsp_valid arrives after release → no response, state IDLE, outputs 0.
